// File: rtl/monitor_regbank_pkg.sv
// Shared types for the byte-stream register monitor: FSM states, reply status codes, id decoding.
// Pure declarations; no timing or backpressure of its own.
package monitor_regbank_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        WDATA,
        COMMIT,
        STATUS,
        RDATA
    } state_e;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_ID  = 8'h01;
    localparam logic [7:0] ST_BAD_LEN = 8'h02;

    // Bit of the command byte that selects a write.
    localparam int RW_BIT = 7;

    // Read-only inputs occupy the top of the 7-bit id space.
    function automatic logic is_ro_id(input logic [6:0] id, input int n_ro);
        return (int'(id) >= (128 - n_ro));
    endfunction

endpackage

// File: rtl/monitor_timeout.sv
// Inter-byte watchdog: down-counter reloaded on restart, counting while enabled; expired when it hits zero.
// Expiry is seen TIMEOUT_CYC-1 enabled cycles after the last restart; no backpressure.
module monitor_timeout #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = LOAD;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/monitor_regbank.sv
// Byte-stream command engine over a bank of RW registers and RO inputs; one status byte per command, read data follows.
// Write commits one cycle after the last byte, status the cycle after; tx bytes held until tx_ready, one idle cycle between bytes.
module monitor_regbank
    import monitor_regbank_pkg::*;
#(
    parameter int N_RW        = 5,
    parameter int N_RO        = 4,
    parameter int REG_BYTES   = 4,
    parameter logic [N_RW*8*REG_BYTES-1:0] RW_RESET = '0,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk50,
    input  logic                          reset_n,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_error,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    input  logic                          tx_ready,
    output logic [N_RW*8*REG_BYTES-1:0]   rw_regs,
    output logic [N_RW-1:0]               rw_wstb,
    input  logic [N_RO*8*REG_BYTES-1:0]   ro_regs,
    output logic                          busy,
    output logic [7:0]                    err_count
);

    localparam int REG_BITS = 8 * REG_BYTES;

    state_e                     state_q;
    logic                       cmd_rw_q;
    logic [6:0]                 cmd_id_q;
    logic [7:0]                 len_q;
    logic [7:0]                 idx_q;
    logic [7:0]                 status_q;
    logic [REG_BITS-1:0]        buf_q;
    logic [N_RW*REG_BITS-1:0]   rw_q;
    logic [N_RW-1:0]            wstb_q;
    logic                       tx_valid_q;
    logic [7:0]                 tx_data_q;
    logic [7:0]                 err_q;

    logic                       in_rx_phase;
    logic                       in_tx_phase;
    logic                       tmo_restart;
    logic                       tmo_expired;
    logic                       err_inc;
    logic                       id_in_rw;
    logic                       id_in_ro;
    logic                       bad_len;
    logic                       bad_id;
    logic [7:0]                 status_eval;
    logic                       last_wbyte;
    logic [REG_BITS-1:0]        rd_word;
    logic [REG_BITS-1:0]        buf_merged;
    logic [REG_BITS-1:0]        wr_word;

    assign in_rx_phase = (state_q == LEN) || (state_q == WDATA);
    assign in_tx_phase = (state_q == COMMIT) || (state_q == STATUS) || (state_q == RDATA);

    // Status is judged on the len byte as it arrives, so the reply can be queued on that same edge.
    assign id_in_rw    = int'(cmd_id_q) < N_RW;
    assign id_in_ro    = is_ro_id(cmd_id_q, N_RO);
    assign bad_len     = (rx_data == 8'd0) || (int'(rx_data) > REG_BYTES);
    assign bad_id      = cmd_rw_q ? !id_in_rw : !(id_in_rw || id_in_ro);
    assign status_eval = bad_len ? ST_BAD_LEN : (bad_id ? ST_BAD_ID : ST_OK);
    assign last_wbyte  = (idx_q == (len_q - 8'd1));

    assign tmo_restart = rx_valid && ((state_q == IDLE) || in_rx_phase);

    assign err_inc = ((state_q == IDLE) && rx_error)
                  || (in_rx_phase && (rx_error || (!rx_valid && tmo_expired)))
                  || (in_tx_phase && rx_valid);

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_RW; k++) begin
            if (int'(cmd_id_q) == k) begin
                rd_word = rw_q[k*REG_BITS +: REG_BITS];
            end
        end
        for (int j = 0; j < N_RO; j++) begin
            if (int'(cmd_id_q) == (128 - N_RO + j)) begin
                rd_word = ro_regs[j*REG_BITS +: REG_BITS];
            end
        end
    end

    // Bytes at or above len keep the register's current contents.
    always_comb begin
        buf_merged = buf_q;
        wr_word    = rd_word;
        for (int b = 0; b < REG_BYTES; b++) begin
            if (int'(idx_q) == b) begin
                buf_merged[b*8 +: 8] = rx_data;
            end
            if (b < int'(len_q)) begin
                wr_word[b*8 +: 8] = buf_merged[b*8 +: 8];
            end
        end
    end

    monitor_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (clk50),
        .rst_ni    (reset_n),
        .restart_i (tmo_restart),
        .enable_i  (in_rx_phase),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cmd_rw_q   <= 1'b0;
            cmd_id_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            status_q   <= ST_OK;
            buf_q      <= '0;
            rw_q       <= RW_RESET;
            wstb_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= '0;
        end else begin
            wstb_q <= '0;
            if (err_inc && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (rx_valid && !rx_error) begin
                        cmd_rw_q <= rx_data[RW_BIT];
                        cmd_id_q <= rx_data[6:0];
                        state_q  <= LEN;
                    end
                end

                LEN: begin
                    if (rx_error) begin
                        state_q <= IDLE;
                    end else if (rx_valid) begin
                        len_q    <= rx_data;
                        status_q <= status_eval;
                        idx_q    <= '0;
                        if (cmd_rw_q && !bad_len) begin
                            state_q <= WDATA;
                        end else begin
                            // Read snapshot taken here so all reply bytes come from one instant.
                            buf_q      <= rd_word;
                            state_q    <= STATUS;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= status_eval;
                        end
                    end else if (tmo_expired) begin
                        state_q <= IDLE;
                    end
                end

                WDATA: begin
                    if (rx_error) begin
                        state_q <= IDLE;
                    end else if (rx_valid) begin
                        buf_q <= buf_merged;
                        if (last_wbyte) begin
                            state_q <= COMMIT;
                            if (status_q == ST_OK) begin
                                for (int k = 0; k < N_RW; k++) begin
                                    if (int'(cmd_id_q) == k) begin
                                        rw_q[k*REG_BITS +: REG_BITS] <= wr_word;
                                        wstb_q[k]                    <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end else if (tmo_expired) begin
                        state_q <= IDLE;
                    end
                end

                COMMIT: begin
                    state_q    <= STATUS;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= status_q;
                end

                STATUS: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        idx_q      <= '0;
                        if (!cmd_rw_q && (status_q == ST_OK)) begin
                            state_q <= RDATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end

                RDATA: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= buf_q[7:0];
                        buf_q      <= buf_q >> 8;
                    end else if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (last_wbyte) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rw_regs   = rw_q;
    assign rw_wstb   = wstb_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign err_count = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_monitor_regbank.sv
// Directed bench for monitor_regbank: expected tx bytes are queued as commands are sent and
// popped by a tx-side responder that also applies backpressure and checks data stability.
module tb_monitor_regbank;

    localparam int N_RW      = 5;
    localparam int N_RO      = 4;
    localparam int REG_BYTES = 4;
    localparam int TMO       = 40;
    localparam logic [159:0] RW_RST = {32'h44444444, 32'h33333333, 32'h22222222,
                                       32'h11111111, 32'hAABBCCDD};

    logic         clk50     = 1'b0;
    logic         reset_n   = 1'b0;
    logic         rx_valid  = 1'b0;
    logic [7:0]   rx_data   = 8'h00;
    logic         rx_error  = 1'b0;
    logic         tx_ready  = 1'b0;
    logic [127:0] ro_regs   = {32'hCAFEF00D, 32'h03030303, 32'h02020202, 32'h01010101};
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic [159:0] rw_regs;
    logic [4:0]   rw_wstb;
    logic         busy;
    logic [7:0]   err_count;

    int           checks      = 0;
    int           errors      = 0;
    int           stall_cfg   = 0;
    int           wstb_cycles = 0;
    logic [4:0]   last_wstb   = '0;
    logic [7:0]   exp_q[$];
    logic [159:0] rw_model;

    always #5 clk50 = ~clk50;

    monitor_regbank #(
        .N_RW        (N_RW),
        .N_RO        (N_RO),
        .REG_BYTES   (REG_BYTES),
        .RW_RESET    (RW_RST),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk50     (clk50),
        .reset_n   (reset_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_error  (rx_error),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rw_regs   (rw_regs),
        .rw_wstb   (rw_wstb),
        .ro_regs   (ro_regs),
        .busy      (busy),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk50);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic rx_err_pulse();
        rx_error = 1'b1;
        @(posedge clk50);
        #1;
        rx_error = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid || busy) && n < 500) begin
            @(posedge clk50);
            #1;
            n++;
        end
        check({tag, "_pending"}, 192'(exp_q.size()), 192'(0));
        check({tag, "_idle"}, 192'(busy), 192'(1'b0));
    endtask

    initial begin : wstb_mon
        forever begin
            @(negedge clk50);
            if (rw_wstb != '0) begin
                wstb_cycles++;
                last_wstb = rw_wstb;
            end
        end
    end

    initial begin : responder
        int         waited;
        logic [7:0] held;
        logic [8:0] e;
        waited = 0;
        held   = '0;
        forever begin
            @(negedge clk50);
            tx_ready = 1'b0;
            if (reset_n && tx_valid) begin
                if (waited == 0) begin
                    held = tx_data;
                end else begin
                    check("tx_hold", 192'(tx_data), 192'(held));
                end
                if (waited >= stall_cfg) begin
                    tx_ready = 1'b1;
                    waited   = 0;
                    if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
                    else e = 9'h100;
                    check("tx_byte", 192'({1'b0, tx_data}), 192'(e));
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit reached;
        repeat (3) @(posedge clk50);
        #1;
        check("rst_rw_regs", 192'(rw_regs), 192'(RW_RST));
        check("rst_tx_valid", 192'(tx_valid), 192'(1'b0));
        check("rst_tx_data", 192'(tx_data), 192'(8'h00));
        check("rst_busy", 192'(busy), 192'(1'b0));
        check("rst_err", 192'(err_count), 192'(8'h00));
        check("rst_wstb", 192'(rw_wstb), 192'(5'b0));
        reset_n = 1'b1;
        @(posedge clk50);
        #1;
        rw_model = RW_RST;

        // Full write to reg2 with cycle-exact commit/status timing
        exp_q.push_back(8'h00);
        send(8'h82); send(8'h04); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        rw_model[64 +: 32] = 32'h12345678;
        check("fw_wstb_n1", 192'(rw_wstb), 192'(5'b00100));
        check("fw_regs_n1", 192'(rw_regs), 192'(rw_model));
        check("fw_txv_n1", 192'(tx_valid), 192'(1'b0));
        @(posedge clk50);
        #1;
        check("fw_wstb_n2", 192'(rw_wstb), 192'(5'b0));
        check("fw_txv_n2", 192'(tx_valid), 192'(1'b1));
        check("fw_txd_n2", 192'(tx_data), 192'(8'h00));
        wait_done("fw");
        check("fw_wstb_cycles", 192'(wstb_cycles), 192'(1));

        // Partial write of byte 0 of reg0, then full read-back
        exp_q.push_back(8'h00);
        send(8'h80); send(8'h01); send(8'hEE);
        rw_model[0 +: 32] = 32'hAABBCCEE;
        wait_done("pw");
        check("pw_regs", 192'(rw_regs), 192'(rw_model));
        check("pw_wstb", 192'(last_wstb), 192'(5'b00001));
        check("pw_wstb_cycles", 192'(wstb_cycles), 192'(2));
        exp_q.push_back(8'h00); exp_q.push_back(8'hEE); exp_q.push_back(8'hCC);
        exp_q.push_back(8'hBB); exp_q.push_back(8'hAA);
        send(8'h00); send(8'h04);
        wait_done("rd0");

        // Read-only id 127 with 5-cycle stalls per byte
        stall_cfg = 5;
        exp_q.push_back(8'h00); exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
        send(8'h7F); send(8'h02);
        wait_done("ro");
        stall_cfg = 0;

        // Error replies
        exp_q.push_back(8'h02);
        send(8'hFF); send(8'h05);
        wait_done("badlen_prio");
        exp_q.push_back(8'h01);
        send(8'hFF); send(8'h01); send(8'h55);
        wait_done("wr_ro");
        check("wr_ro_wstb", 192'(wstb_cycles), 192'(2));
        check("wr_ro_regs", 192'(rw_regs), 192'(rw_model));
        exp_q.push_back(8'h02);
        send(8'h01); send(8'h00);
        wait_done("len0");
        exp_q.push_back(8'h01);
        send(8'h10); send(8'h04);
        wait_done("badid");
        exp_q.push_back(8'h02);
        send(8'h03); send(8'h05);
        wait_done("len5");

        // Inter-byte timeout
        send(8'h81); send(8'h04); send(8'h11);
        repeat (TMO - 2) @(posedge clk50);
        #1;
        check("tmo_busy_before", 192'(busy), 192'(1'b1));
        @(posedge clk50);
        #1;
        check("tmo_busy_after", 192'(busy), 192'(1'b0));
        check("tmo_err", 192'(err_count), 192'(8'd1));
        check("tmo_regs", 192'(rw_regs), 192'(rw_model));
        check("tmo_wstb", 192'(wstb_cycles), 192'(2));

        // rx_error mid-write
        send(8'h81); send(8'h04); send(8'h22);
        rx_err_pulse();
        check("rxerr_busy", 192'(busy), 192'(1'b0));
        check("rxerr_err", 192'(err_count), 192'(8'd2));
        check("rxerr_regs", 192'(rw_regs), 192'(rw_model));

        // Error counter saturation
        repeat (260) rx_err_pulse();
        check("sat_err", 192'(err_count), 192'(8'hFF));
        check("sat_busy", 192'(busy), 192'(1'b0));

        // Async reset while a read reply is in flight
        stall_cfg = 3;
        exp_q.push_back(8'h00); exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        send(8'h02); send(8'h04);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge clk50);
            #1;
            if (exp_q.size() == 3 && tx_valid) reached = 1'b1;
        end
        check("arst_reached_rdata", 192'(reached), 192'(1'b1));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_txv_async", 192'(tx_valid), 192'(1'b0));
        exp_q.delete();
        stall_cfg = 0;
        @(posedge clk50);
        #1;
        check("arst_regs", 192'(rw_regs), 192'(RW_RST));
        check("arst_err", 192'(err_count), 192'(8'h00));
        check("arst_busy", 192'(busy), 192'(1'b0));
        reset_n = 1'b1;
        @(posedge clk50);
        #1;
        rw_model = RW_RST;
        exp_q.push_back(8'h00); exp_q.push_back(8'h22); exp_q.push_back(8'h22);
        exp_q.push_back(8'h22); exp_q.push_back(8'h22);
        send(8'h02); send(8'h04);
        wait_done("post_rst");
        check("post_rst_regs", 192'(rw_regs), 192'(rw_model));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/monitor_regbank.md
Name: monitor_regbank

Overview:
- Parametrised successor of the UART register monitor: a byte-stream command engine serving a configurable bank of read/write registers and read-only status inputs.
- Runs entirely on clk50 and exchanges bytes with uart_rx/uart_tx through a valid/ready interface, so there is no baud-clocked state machine.
- Adds over the previous generation:
  - status reply byte for every command
  - id and length checking
  - inter-byte timeout recovery
  - byte-granular partial writes
  - per-register write strobes
  - saturating error counter

Parameters:
N_RW, 5, number of read/write registers (ids 0..N_RW-1)
N_RO, 4, number of read-only inputs (ids 128-N_RO..127)
REG_BYTES, 4, bytes per register; REG_BITS = 8*REG_BYTES
RW_RESET, {N_RW*REG_BITS{1'b0}}, flat reset value; register k = slice k
TIMEOUT_CYC, 50000, max clk50 cycles between bytes within a command (1 ms)

Ports:
clk50  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
rx_data  in  8  received byte
rx_error  in  1  one-cycle pulse: framing/parity error on current byte
tx_valid  out  1  tx_data is valid; held until tx_ready
tx_data  out  8  byte to transmit
tx_ready  in  1  transmitter accepts tx_data this cycle
rw_regs  out  N_RW*REG_BITS  read/write register contents, register k at [k*REG_BITS +: REG_BITS]
rw_wstb  out  N_RW  one-cycle pulse when register k is committed
ro_regs  in  N_RO*REG_BITS  read-only inputs; id 128-N_RO+j is slice j
busy  out  1  high in every state except IDLE
err_count  out  8  aborted-command count, saturating at 255

Behaviour:
- Reset (async assert, sync release): state IDLE; rw_regs=RW_RESET; rw_wstb=0; tx_valid=0; tx_data=0; busy=0; err_count=0; timeout counter=0.
- Frame format:
  - byte0: cmd = {rw, id[6:0]}, rw=1 means write.
  - byte1: len.
  - Write: len data bytes follow, LSB byte first. Monitor replies with a single status byte.
  - Read: monitor replies with a status byte, then len data bytes LSB first, only if status=OK.
- Status codes: 0x00 OK, 0x01 BAD_ID, 0x02 BAD_LEN.
  - BAD_ID: id not in either range, or write to an RO id.
  - BAD_LEN: len==0 or len>REG_BYTES. BAD_LEN takes priority over BAD_ID.
- States:
  - IDLE: rx_valid -> latch cmd, go LEN.
  - LEN: rx_valid -> latch len and evaluate status.
    - write with len valid -> WDATA
    - write with bad len -> STATUS; no data bytes are consumed
    - read -> STATUS; on the same edge snapshot the addressed register into the shift buffer (atomic)
  - WDATA: each rx_valid stores the byte at index idx; idx++.
    - After the byte with idx==len-1 -> COMMIT.
    - With BAD_ID, bytes are consumed but discarded.
  - COMMIT (1 cycle), only if status OK:
    - bytes 0..len-1 of register id update; bytes >= len are unchanged.
    - rw_wstb[id]=1 for this cycle only.
    - Go STATUS.
  - STATUS: tx_valid=1, tx_data=status. On tx_ready: read with OK -> RDATA with idx=0; otherwise -> IDLE.
  - RDATA: tx_data=buffer[idx]. On tx_ready: idx++. The byte with idx==len-1 accepted -> IDLE.
- Timing:
  - Last write byte at cycle N -> rw_regs visible and rw_wstb high at N+1 -> tx_valid high at N+2.
  - Consecutive tx bytes are spaced by at least 1 cycle after each tx_ready.
- tx handshake: tx_data is stable while tx_valid=1 && !tx_ready; tx_valid drops after the final accepted byte.
- Timeout: in LEN/WDATA the counter resets on each rx_valid. On reaching TIMEOUT_CYC-1: abort to IDLE, no reply, no register change, err_count++.
- rx_error in LEN/WDATA: abort to IDLE, err_count++. rx_error in IDLE: byte ignored, err_count++.
- rx_valid during STATUS/RDATA/COMMIT: byte dropped, err_count++, transmission continues.
- rx_valid and rx_error in the same cycle: treated as error.
- err_count holds at 255 (no wrap).
- reset_n low mid-command: immediate abort. tx_valid drops asynchronously; partial write data is discarded.

Decomposition:
- Package monitor_regbank_pkg:
  - state enum (IDLE, LEN, WDATA, COMMIT, STATUS, RDATA)
  - status codes ST_OK/ST_BAD_ID/ST_BAD_LEN
  - RW_BIT index
  - function is_ro_id(id, N_RO)
- Sub-module monitor_timeout: loadable down-counter with restart/enable inputs and an expired output. Width is $clog2(TIMEOUT_CYC).

Test Plan:
- Full write: rx 0x82,0x04,0x78,0x56,0x34,0x12 -> rw_regs slice2=0x12345678; rw_wstb=3'b100 pulse for 1 cycle; tx 0x00.
- Partial write then read:
  - Preload reg0=0xAABBCCDD.
  - Write 0x80,0x01,0xEE -> reg0=0xAABBCCEE.
  - Read 0x00,0x04 -> tx 0x00,0xEE,0xCC,0xBB,0xAA.
- RO read with backpressure: ro_regs slice3=0xCAFEF00D, read 0x7F,0x02, tx_ready low 5 cycles per byte -> tx 0x00,0x0D,0xF0; tx_data stable while stalled.
- Error replies:
  - Write to RO id: 0xFF,0x01,0x55 -> tx 0x01, no wstb.
  - Read 0x01,0x00 -> tx 0x02 only.
  - Read id 0x10 len 4 -> tx 0x01 only.
- Timeout/abort:
  - 0x81,0x04,0x11 then idle TIMEOUT_CYC cycles -> IDLE, err_count=1, reg1 unchanged, no tx.
  - rx_error mid-WDATA -> err_count=2.
- Async reset mid-RDATA: reset_n low while tx_valid=1 -> tx_valid=0 immediately, rw_regs=RW_RESET, err_count=0; next command works normally.
